latch_using_mux: RTL and testbench



---
 rtl/latch_using_mux_pkg.sv | 12 +
 rtl/latch_using_mux_mux21.sv | 14 +
 rtl/latch_using_mux.sv | 44 ++++
 tb/tb_latch_using_mux.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/latch_using_mux_pkg.sv
// rtl/latch_using_mux_pkg.sv - shared defaults for the mux-based latch cell
`timescale 1ns/100ps

package latch_using_mux_pkg;

  // One-bit cell unless the instantiating design asks for a wider bus.
  localparam int DEFAULT_WIDTH = 1;

  // Every bit of the hold register clears to this level on reset.
  localparam logic DEFAULT_RESET_BIT = 1'b0;

endpackage : latch_using_mux_pkg

// File: rtl/latch_using_mux_mux21.sv
// rtl/latch_using_mux_mux21.sv - single-bit 2:1 multiplexer, y = sel ? b : a
`timescale 1ns/100ps

module mux21 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  // Pure select; no storage, so no clock or reset here.
  assign y = sel ? b : a;

endmodule : mux21

// File: rtl/latch_using_mux.sv
// rtl/latch_using_mux.sv - level-sensitive D latch built from a 2:1 mux and a clocked hold register
`timescale 1ns/100ps

module latch_using_mux
  import latch_using_mux_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{DEFAULT_RESET_BIT}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D,
  input  logic             en,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_n
);

  // Last value seen at a clock edge while transparent. Keeping the state in
  // a real flop instead of a feedback path leaves the cell timing-analysable.
  logic [WIDTH-1:0] hold;

  // Hold register: reset wins over capture; capture only while en is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold <= RESET_VALUE;
    end else if (en) begin
      hold <= D;
    end
  end

  // Per-bit output mux: transparent path from D when en=1, stored bit otherwise.
  // The mux is deliberately not gated by rst so D still flows through during reset.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit_mux
    mux21 u_mux (
      .a   (hold[i]),
      .b   (D[i]),
      .sel (en),
      .y   (Q[i])
    );
  end

  assign Q_n = ~Q;

endmodule : latch_using_mux

// File: tb/tb_latch_using_mux.sv
// tb/tb_latch_using_mux.sv - self-checking bench for latch_using_mux (WIDTH=8 and WIDTH=1)
`timescale 1ns/100ps

module tb_latch_using_mux;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] d8;
  logic       d1;
  logic [7:0] q8, qn8;
  logic       q1, qn1;

  int tests = 0;
  int fails = 0;

  // 1 ns clock: posedges at 0.5, 1.5, ...; negedges at 1.0, 2.0, ...
  always #0.5 clk = ~clk;

  assign d1 = d8[0];

  latch_using_mux #(.WIDTH(8)) dut8 (
    .clk (clk), .rst (rst), .D (d8), .en (en), .Q (q8), .Q_n (qn8)
  );

  latch_using_mux dut1 (
    .clk (clk), .rst (rst), .D (d1), .en (en), .Q (q1), .Q_n (qn1)
  );

  // Reference: "what was the data when the latch last looked at it".
  logic [7:0] last_seen;
  bit         seen_valid = 1'b0;

  always @(posedge clk) begin
    if (rst === 1'b1) begin
      last_seen  = 8'h00;
      seen_valid = 1'b1;
    end else if (en === 1'b1) begin
      last_seen  = d8;
      seen_valid = 1'b1;
    end
  end

  function automatic logic [7:0] expect_q();
    return en ? d8 : last_seen;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison on every negedge once the output is defined.
  always @(negedge clk) begin
    if (en === 1'b1 || seen_valid) begin
      check("model_q8",  q8,           expect_q());
      check("model_qn8", qn8,          ~expect_q());
      check("model_q1",  {7'b0, q1},   {7'b0, expect_q() & 8'h01});
      check("model_qn1", {7'b0, qn1},  {7'b0, ~expect_q() & 8'h01});
    end
  end

  // Align to a quarter period after a rising edge, clear of both clock edges.
  task automatic sync();
    @(posedge clk);
    #0.25;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    d8  = 8'h01;

    // Reset hold: two edges with rst high, en low, D high.
    sync();
    sync();
    check("rst_q1",  {7'b0, q1},  8'h00);
    check("rst_qn1", {7'b0, qn1}, 8'h01);
    check("rst_q8",  q8,          8'h00);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d8 = {7'b0, i[0]};
      sync();
    end
    check("rst_hold_q1", {7'b0, q1}, 8'h00);

    // Transparency: D changes faster than the clock, Q follows immediately.
    en = 1'b1;
    d8 = 8'h01; #0.1; check("transp_1", q8, 8'h01);
    #0.2; d8 = 8'h00; #0.1; check("transp_0", q8, 8'h00);
    #0.2; d8 = 8'h01; #0.1; check("transp_1b", q8, 8'h01);

    // Hold: D=1 over three edges, en falls, then D drops.
    sync(); sync(); sync();
    en = 1'b0;
    #0.1; d8 = 8'h00;
    #0.05; check("hold_immediate", q8, 8'h01);
    for (int i = 0; i < 5; i++) sync();
    check("hold_after", q8, 8'h01);

    // en toggles every 5 ns, D moves on its own schedule.
    sync();
    for (int t = 0; t < 20; t++) begin
      en = ((t / 5) % 2) == 0;
      case (t)
        3:  d8 = 8'h01;
        8:  d8 = 8'h00;
        10: d8 = 8'h01;
        16: d8 = 8'h00;
        default: ;
      endcase
      #0.1;
      if (t == 7)  check("async_hold_t7",  q8, 8'h01);
      if (t == 17) check("async_hold_t17", q8, 8'h01);
      #0.9;
    end

    // Reset during transparency, then en falls with rst still high.
    sync();
    en = 1'b1; d8 = 8'h01; rst = 1'b1;
    #0.1; check("rst_transp_q", q8, 8'h01);
    sync();
    en = 1'b0;
    sync();
    check("rst_transp_after", q8, 8'h00);
    rst = 1'b0;

    // Eight-bit capture and complement.
    en = 1'b1; d8 = 8'hA5;
    sync(); sync();
    en = 1'b0;
    #0.1; d8 = 8'h3C;
    #0.05; check("w8_q",  q8,  8'hA5);
    check("w8_qn", qn8, 8'h5A);
    sync();
    check("w8_q_later", q8, 8'hA5);
    en = 1'b1;
    #0.1; check("w8_reopen", q8, 8'h3C);
    sync();

    // Pulse on en that sees no clock edge leaves the hold untouched.
    en = 1'b0; d8 = 8'hFF;
    sync();
    en = 1'b1;
    #0.1; check("pulse_mid", q8, 8'hFF);
    #0.2; en = 1'b0;
    #0.1; check("pulse_after", q8, 8'h3C);

    // Reset mid-hold.
    sync();
    rst = 1'b1;
    sync();
    check("rst_midhold", q8, 8'h00);
    rst = 1'b0;

    // Randomized traffic with a second mid-cycle D change.
    for (int i = 0; i < 2000; i++) begin
      sync();
      en  = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 31) == 0);
      d8  = 8'($urandom);
      #0.45;
      d8  = 8'($urandom);
    end

    sync();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_latch_using_mux
